flash_cmd_sequencer: RTL and testbench
======================================

// Module: flash_cmd_sequencer
// PURPOSE
//  Sequences StrataFlash-style command cycles (read-array, program, block erase, status poll,
//  clear-status) over the byte-wide Flash bus-cycle module (addr/data/direction_rw/fb_start/fb_done).
//  Sits between score-board logic and Flash; turns one start pulse into a full multi-cycle op.
//  Reports completion, SR error bits and poll timeout.
// PARAMETERS
//  AW        8     address width, passed to Flash addr bus
//  DW        8     data width, also the command/status byte width
//  POLL_MAX  1024  max status-register reads before err_timeout is set
// PORTS
//  CLK_50MHZ   in   1   system clock, all logic on rising edge
//  RST         in   1   asynchronous, active-low reset
//  start       in   1   1-cycle op request; sampled only in IDLE
//  op          in   2   00 READ, 01 PROGRAM, 10 ERASE_BLOCK, 11 CLEAR_STATUS
//  op_addr     in   AW  target address (sampled with start)
//  op_wdata    in   DW  program data (sampled with start)
//  busy        out  1   high from cycle after start until done
//  done        out  1   1-cycle pulse, op finished
//  rdata       out  DW  READ result, valid from done until next start
//  status      out  DW  last status byte read (SR)
//  err         out  1   with done: SR5|SR4|SR3|SR1 set, or timeout
//  err_timeout out  1   with done: POLL_MAX exceeded
//  fb_addr     out  AW  to Flash addr
//  fb_wdata    out  DW  to Flash data (write cycles)
//  fb_rdata    in   DW  from Flash, valid on fb_done of read cycle
//  fb_rw       out  1   1 = write cycle, 0 = read cycle (direction_rw)
//  fb_start    out  1   1-cycle pulse, launches one bus cycle
//  fb_done     in   1   1-cycle pulse, bus cycle complete
// BEHAVIOUR
//  Reset: state IDLE; busy, done, err, err_timeout, fb_start, fb_rw = 0; fb_addr, fb_wdata, rdata,
//   status = 0; poll counter = 0. Reset mid-op aborts immediately, no bus cycle is completed.
//  Bus rule: each bus state drives fb_addr/fb_wdata/fb_rw, pulses fb_start one cycle on entry,
//   then holds outputs stable and waits for fb_done; next state taken on the fb_done cycle.
//   Only one bus cycle is outstanding at a time.
//  States / command bytes (all writes to op_addr):
//   IDLE    : start -> latch op/op_addr/op_wdata, busy=1, go per op.
//   CMD1    : write 40h (PROGRAM) / 20h (ERASE) / 50h (CLEAR) / FFh (READ).
//   CMD2    : write op_wdata (PROGRAM) / D0h (ERASE) -> STAT_CMD.
//             READ: CMD1 -> RD_DATA. CLEAR: CMD1 -> RESTORE.
//   RD_DATA : read cycle; on fb_done rdata <= fb_rdata -> FINISH.
//   STAT_CMD: write 70h -> STAT_RD.
//   STAT_RD : read cycle; status <= fb_rdata; count++. SR7=1 -> RESTORE;
//             SR7=0 and count < POLL_MAX -> STAT_RD; count = POLL_MAX -> err_timeout, RESTORE.
//   RESTORE : write FFh (back to read-array) -> FINISH.
//   FINISH  : done=1 one cycle, busy=0, err per above -> IDLE.
//  Poll counter cleared on start; width clog2(POLL_MAX+1), never wraps.
//  err/err_timeout held until next start; cleared on start.
//  start while busy: ignored, no queueing. start and done in same cycle cannot occur.
//  Latency (bus cycles): READ 2; CLEAR 2; PROGRAM 4+n; ERASE 4+n, n = status reads.
//   done asserts the cycle after the last fb_done.
//  fb_done outside a wait state is ignored.
// TESTING
//  1 READ op_addr=35h, bus model returns C9h -> writes FFh@35h, read@35h, rdata=C9h, done, err=0.
//  2 PROGRAM 35h<=C9h, SR=00h x3 then 80h -> 40h, C9h, 70h, 4 reads, FFh; status=80h, err=0.
//  3 ERASE 10h, SR returns A0h -> 20h, D0h, 70h, 1 read, FFh; err=1, err_timeout=0, status=A0h.
//  4 PROGRAM, POLL_MAX=4, SR stays 00h -> exactly 4 status reads, FFh written, err=err_timeout=1.
//  5 start pulses while busy and after a CLEAR op -> ignored; CLEAR issues 50h, FFh, done.
//  6 RST low mid-STAT_RD -> outputs 0 asynchronously; next READ after release completes normally.

Source files
------------

// File: rtl/flash_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : flash_cmd_sequencer
// Description : Turns one start pulse into a full StrataFlash command sequence
//               (read-array, program, block erase, status poll, clear-status)
//               over a single-outstanding byte-wide Flash bus-cycle interface.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_cmd_sequencer #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int POLL_MAX = 1024
) (
    input  logic          CLK_50MHZ,
    input  logic          RST,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] op_addr,
    input  logic [DW-1:0] op_wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] status,
    output logic          err,
    output logic          err_timeout,
    output logic [AW-1:0] fb_addr,
    output logic [DW-1:0] fb_wdata,
    input  logic [DW-1:0] fb_rdata,
    output logic          fb_rw,
    output logic          fb_start,
    input  logic          fb_done
);

    localparam int CW = $clog2(POLL_MAX + 1);

    localparam logic [1:0] c_OP_READ    = 2'b00;
    localparam logic [1:0] c_OP_PROGRAM = 2'b01;
    localparam logic [1:0] c_OP_ERASE   = 2'b10;
    localparam logic [1:0] c_OP_CLEAR   = 2'b11;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_CMD1     = 3'd1;
    localparam logic [2:0] c_ST_CMD2     = 3'd2;
    localparam logic [2:0] c_ST_RD_DATA  = 3'd3;
    localparam logic [2:0] c_ST_STAT_CMD = 3'd4;
    localparam logic [2:0] c_ST_STAT_RD  = 3'd5;
    localparam logic [2:0] c_ST_RESTORE  = 3'd6;
    localparam logic [2:0] c_ST_FINISH   = 3'd7;

    localparam logic [DW-1:0] c_CMD_READ_ARRAY = DW'(8'hFF);
    localparam logic [DW-1:0] c_CMD_PROGRAM    = DW'(8'h40);
    localparam logic [DW-1:0] c_CMD_ERASE      = DW'(8'h20);
    localparam logic [DW-1:0] c_CMD_CONFIRM    = DW'(8'hD0);
    localparam logic [DW-1:0] c_CMD_CLEAR      = DW'(8'h50);
    localparam logic [DW-1:0] c_CMD_STATUS     = DW'(8'h70);

    logic [2:0]    r_state;
    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [CW-1:0] r_poll_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_err_timeout;
    logic          r_err_pend;
    logic          r_tmo_pend;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_status;
    logic [AW-1:0] r_fb_addr;
    logic [DW-1:0] r_fb_wdata;
    logic          r_fb_rw;
    logic          r_fb_start;

    logic [2:0]    w_next;
    logic          w_launch;
    logic          w_rw;
    logic [DW-1:0] w_wdata;
    logic          w_bus_done;
    logic [CW-1:0] w_cnt_inc;
    logic          w_sr_ready;
    logic          w_sr_err;
    logic          w_poll_exhausted;

    // A completion arriving in the launch cycle cannot belong to this cycle.
    assign w_bus_done       = fb_done & ~r_fb_start;
    assign w_cnt_inc        = r_poll_cnt + CW'(1);
    assign w_sr_ready       = fb_rdata[7];
    assign w_sr_err         = fb_rdata[5] | fb_rdata[4] | fb_rdata[3] | fb_rdata[1];
    assign w_poll_exhausted = (w_cnt_inc == CW'(POLL_MAX));

    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        w_rw     = r_fb_rw;
        w_wdata  = r_fb_wdata;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next   = c_ST_CMD1;
                    w_launch = 1'b1;
                    w_rw     = 1'b1;
                    case (op)
                        c_OP_READ:    w_wdata = c_CMD_READ_ARRAY;
                        c_OP_PROGRAM: w_wdata = c_CMD_PROGRAM;
                        c_OP_ERASE:   w_wdata = c_CMD_ERASE;
                        default:      w_wdata = c_CMD_CLEAR;
                    endcase
                end
            end
            c_ST_CMD1: begin
                if (w_bus_done) begin
                    w_launch = 1'b1;
                    w_rw     = 1'b1;
                    case (r_op)
                        c_OP_READ: begin
                            w_next = c_ST_RD_DATA;
                            w_rw   = 1'b0;
                        end
                        c_OP_PROGRAM: begin
                            w_next  = c_ST_CMD2;
                            w_wdata = r_wdata;
                        end
                        c_OP_ERASE: begin
                            w_next  = c_ST_CMD2;
                            w_wdata = c_CMD_CONFIRM;
                        end
                        default: begin
                            w_next  = c_ST_RESTORE;
                            w_wdata = c_CMD_READ_ARRAY;
                        end
                    endcase
                end
            end
            c_ST_CMD2: begin
                if (w_bus_done) begin
                    w_next   = c_ST_STAT_CMD;
                    w_launch = 1'b1;
                    w_rw     = 1'b1;
                    w_wdata  = c_CMD_STATUS;
                end
            end
            c_ST_STAT_CMD: begin
                if (w_bus_done) begin
                    w_next   = c_ST_STAT_RD;
                    w_launch = 1'b1;
                    w_rw     = 1'b0;
                end
            end
            c_ST_STAT_RD: begin
                if (w_bus_done) begin
                    w_launch = 1'b1;
                    if (w_sr_ready || w_poll_exhausted) begin
                        w_next  = c_ST_RESTORE;
                        w_rw    = 1'b1;
                        w_wdata = c_CMD_READ_ARRAY;
                    end else begin
                        w_next = c_ST_STAT_RD;
                        w_rw   = 1'b0;
                    end
                end
            end
            c_ST_RD_DATA, c_ST_RESTORE: begin
                if (w_bus_done) begin
                    w_next = c_ST_FINISH;
                end
            end
            default: begin
                w_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_state       <= c_ST_IDLE;
            r_op          <= 2'b00;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_poll_cnt    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_pend    <= 1'b0;
            r_tmo_pend    <= 1'b0;
            r_rdata       <= '0;
            r_status      <= '0;
            r_fb_addr     <= '0;
            r_fb_wdata    <= '0;
            r_fb_rw       <= 1'b0;
            r_fb_start    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_fb_start <= w_launch;
            r_done     <= 1'b0;
            if (w_launch) begin
                r_fb_rw    <= w_rw;
                r_fb_wdata <= w_wdata;
                r_fb_addr  <= (r_state == c_ST_IDLE) ? op_addr : r_addr;
            end
            if (r_state == c_ST_IDLE && start) begin
                r_op          <= op;
                r_addr        <= op_addr;
                r_wdata       <= op_wdata;
                r_busy        <= 1'b1;
                r_err         <= 1'b0;
                r_err_timeout <= 1'b0;
                r_err_pend    <= 1'b0;
                r_tmo_pend    <= 1'b0;
                r_poll_cnt    <= '0;
            end
            if (w_bus_done && r_state == c_ST_RD_DATA) begin
                r_rdata <= fb_rdata;
            end
            if (w_bus_done && r_state == c_ST_STAT_RD) begin
                r_status   <= fb_rdata;
                r_poll_cnt <= w_cnt_inc;
                if (w_sr_ready) begin
                    r_err_pend <= w_sr_err;
                end else if (w_poll_exhausted) begin
                    r_err_pend <= 1'b1;
                    r_tmo_pend <= 1'b1;
                end
            end
            // Error flags only become visible together with done.
            if (w_next == c_ST_FINISH && r_state != c_ST_FINISH) begin
                r_done        <= 1'b1;
                r_busy        <= 1'b0;
                r_err         <= r_err_pend;
                r_err_timeout <= r_tmo_pend;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign status      = r_status;
    assign err         = r_err;
    assign err_timeout = r_err_timeout;
    assign fb_addr     = r_fb_addr;
    assign fb_wdata    = r_fb_wdata;
    assign fb_rw       = r_fb_rw;
    assign fb_start    = r_fb_start;

endmodule
`default_nettype wire

// File: tb/tb_flash_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_cmd_sequencer
// Description : Randomised bench for flash_cmd_sequencer with a bus responder
//               and a transaction-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_cmd_sequencer;

    localparam int POLL_MAX = 4;

    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_t;
    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] op_addr = 8'h00;
    logic [7:0] op_wdata = 8'h00;
    logic [7:0] fb_rdata = 8'h00;
    logic       fb_done = 1'b0;
    logic       busy, done, err, err_timeout, fb_rw, fb_start;
    logic [7:0] rdata, status, fb_addr, fb_wdata;

    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned cyc = 0;
    int unsigned last_fbd_cyc = 0;

    bus_t       log_q[$];
    bus_t       exp_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] exp_status = 8'h00;
    logic [7:0] exp_rdata = 8'h00;
    logic       exp_err = 1'b0;
    logic       exp_tmo = 1'b0;

    flash_cmd_sequencer #(.AW(8), .DW(8), .POLL_MAX(POLL_MAX)) dut (
        .CLK_50MHZ  (clk),
        .RST        (rst_n),
        .start      (start),
        .op         (op),
        .op_addr    (op_addr),
        .op_wdata   (op_wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .status     (status),
        .err        (err),
        .err_timeout(err_timeout),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_rdata   (fb_rdata),
        .fb_rw      (fb_rw),
        .fb_start   (fb_start),
        .fb_done    (fb_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash bus responder: logs every launched cycle, answers after 1-3 clocks.
    initial begin
        int lat;
        forever begin
            @(posedge clk);
            #1;
            while (fb_start === 1'b1) begin
                log_q.push_back(bus_t'({fb_rw, fb_addr, fb_wdata}));
                if (fb_rw === 1'b0) begin
                    if (rd_q.size() > 0) fb_rdata = rd_q.pop_front();
                    else fb_rdata = 8'h00;
                end
                lat = $urandom_range(1, 3);
                repeat (lat) @(posedge clk);
                #1;
                fb_done = 1'b1;
                last_fbd_cyc = cyc;
                @(posedge clk);
                #1;
                fb_done = 1'b0;
            end
        end
    end

    function automatic bus_t mk(input logic rw, input logic [7:0] a, input logic [7:0] d);
        return bus_t'({rw, a, d});
    endfunction

    // Expected bus transactions and results, built from the command-set rules.
    task automatic model(input logic [1:0] mop, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] rdv, input byte_q_t sr);
        logic found;
        logic [7:0] v;
        exp_q.delete();
        exp_err = 1'b0;
        exp_tmo = 1'b0;
        if (mop == 2'b00) begin
            exp_q.push_back(mk(1'b1, a, 8'hFF));
            exp_q.push_back(mk(1'b0, a, 8'h00));
            exp_rdata = rdv;
        end else if (mop == 2'b11) begin
            exp_q.push_back(mk(1'b1, a, 8'h50));
            exp_q.push_back(mk(1'b1, a, 8'hFF));
        end else begin
            exp_q.push_back(mk(1'b1, a, (mop == 2'b01) ? 8'h40 : 8'h20));
            exp_q.push_back(mk(1'b1, a, (mop == 2'b01) ? wd : 8'hD0));
            exp_q.push_back(mk(1'b1, a, 8'h70));
            found = 1'b0;
            for (int i = 0; i < POLL_MAX; i++) begin
                v = (i < sr.size()) ? sr[i] : 8'h00;
                exp_q.push_back(mk(1'b0, a, 8'h00));
                exp_status = v;
                if (v[7]) begin
                    found = 1'b1;
                    break;
                end
            end
            exp_tmo = ~found;
            exp_err = exp_tmo | ((exp_status & 8'h3A) != 8'h00);
            exp_q.push_back(mk(1'b1, a, 8'hFF));
        end
    endtask

    function automatic bit log_ok();
        if (log_q.size() != exp_q.size()) return 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (log_q[i].rw !== exp_q[i].rw || log_q[i].addr !== exp_q[i].addr) return 1'b0;
            if (exp_q[i].rw && log_q[i].data !== exp_q[i].data) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drives one operation and reports handshake observations; no checking here.
    task automatic run_op(input logic [1:0] mop, input logic [7:0] a, input logic [7:0] wd,
                          input bit ghost, output bit seen_done, output bit busy_ok,
                          output bit lat_ok, output bit pulse_ok);
        log_q.delete();
        @(posedge clk);
        #1;
        start = 1'b1;
        op = mop;
        op_addr = a;
        op_wdata = wd;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_addr = ~a;
        op_wdata = ~wd;
        busy_ok = (busy === 1'b1) && (fb_start === 1'b1) && (done === 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            if (ghost && (i == 2 || i == 5)) begin
                start = 1'b1;
                op = 2'b00;
            end
        end
        lat_ok = seen_done && (cyc == last_fbd_cyc + 1) && (busy === 1'b0);
        @(posedge clk);
        #1;
        pulse_ok = (done === 1'b0) && (busy === 1'b0) && (fb_start === 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, err, err_timeout} !== 4'b0000)
            $display("FAIL reset_flags: got %b required 0000", {busy, done, err, err_timeout});
        else n_pass++;
        n_checks++;
        if ({fb_start, fb_rw} !== 2'b00)
            $display("FAIL reset_fb_ctl: got %b required 00", {fb_start, fb_rw});
        else n_pass++;
        n_checks++;
        if ({fb_addr, fb_wdata} !== 16'h0000)
            $display("FAIL reset_fb_bus: got %h required 0000", {fb_addr, fb_wdata});
        else n_pass++;
        n_checks++;
        if ({rdata, status} !== 16'h0000)
            $display("FAIL reset_data: got %h required 0000", {rdata, status});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_read();
        bit sd, bo, lo, po;
        byte_q_t sr;
        rd_q.delete();
        rd_q.push_back(8'hC9);
        model(2'b00, 8'h35, 8'h00, 8'hC9, sr);
        run_op(2'b00, 8'h35, 8'h00, 1'b0, sd, bo, lo, po);
        n_checks++;
        if (!(sd && bo)) $display("FAIL read_handshake: done=%0d busy_ok=%0d required 1 1", sd, bo);
        else n_pass++;
        n_checks++;
        if (!log_ok()) $display("FAIL read_bus_seq: got %0d cycles required %0d", log_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (!(lo && po)) $display("FAIL read_latency: lat_ok=%0d pulse_ok=%0d required 1 1", lo, po);
        else n_pass++;
        n_checks++;
        if ({rdata, err, err_timeout} !== {exp_rdata, 2'b00})
            $display("FAIL read_result: got %h/%b%b required %h/00", rdata, err, err_timeout, exp_rdata);
        else n_pass++;
    endtask

    task automatic test_program();
        bit sd, bo, lo, po;
        byte_q_t sr;
        sr = '{8'h00, 8'h00, 8'h00, 8'h80};
        rd_q = sr;
        model(2'b01, 8'h35, 8'hC9, 8'h00, sr);
        run_op(2'b01, 8'h35, 8'hC9, 1'b0, sd, bo, lo, po);
        n_checks++;
        if (!(sd && bo && lo && po))
            $display("FAIL prog_handshake: got %b required 1111", {sd, bo, lo, po});
        else n_pass++;
        n_checks++;
        if (!log_ok()) $display("FAIL prog_bus_seq: got %0d cycles required %0d", log_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if ({status, err, err_timeout} !== {8'h80, 2'b00})
            $display("FAIL prog_result: got %h/%b%b required 80/00", status, err, err_timeout);
        else n_pass++;
    endtask

    task automatic test_erase_error();
        bit sd, bo, lo, po;
        byte_q_t sr;
        sr = '{8'hA0};
        rd_q = sr;
        model(2'b10, 8'h10, 8'h00, 8'h00, sr);
        run_op(2'b10, 8'h10, 8'h00, 1'b0, sd, bo, lo, po);
        n_checks++;
        if (!(sd && bo && lo && po))
            $display("FAIL erase_handshake: got %b required 1111", {sd, bo, lo, po});
        else n_pass++;
        n_checks++;
        if (!log_ok()) $display("FAIL erase_bus_seq: got %0d cycles required %0d", log_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if ({status, err, err_timeout} !== {8'hA0, 2'b10})
            $display("FAIL erase_result: got %h/%b%b required a0/10", status, err, err_timeout);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit sd, bo, lo, po;
        byte_q_t sr;
        sr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rd_q = sr;
        model(2'b01, 8'h22, 8'h5A, 8'h00, sr);
        run_op(2'b01, 8'h22, 8'h5A, 1'b0, sd, bo, lo, po);
        n_checks++;
        if (!(sd && bo && lo && po))
            $display("FAIL timeout_handshake: got %b required 1111", {sd, bo, lo, po});
        else n_pass++;
        n_checks++;
        if (!log_ok() || log_q.size() != POLL_MAX + 4)
            $display("FAIL timeout_bus_seq: got %0d cycles required %0d", log_q.size(), POLL_MAX + 4);
        else n_pass++;
        n_checks++;
        if ({status, err, err_timeout} !== {8'h00, 2'b11})
            $display("FAIL timeout_result: got %h/%b%b required 00/11", status, err, err_timeout);
        else n_pass++;
    endtask

    task automatic test_clear_ignore();
        bit sd, bo, lo, po;
        byte_q_t sr;
        rd_q.delete();
        model(2'b11, 8'h77, 8'h00, 8'h00, sr);
        run_op(2'b11, 8'h77, 8'h00, 1'b1, sd, bo, lo, po);
        n_checks++;
        if (!(sd && bo && lo && po))
            $display("FAIL clear_handshake: got %b required 1111", {sd, bo, lo, po});
        else n_pass++;
        n_checks++;
        if (!log_ok()) $display("FAIL clear_bus_seq: got %0d cycles required %0d", log_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if ({err, err_timeout, status} !== {2'b00, exp_status})
            $display("FAIL clear_result: got %b%b/%h required 00/%h", err, err_timeout, status, exp_status);
        else n_pass++;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (log_q.size() != 2 || busy !== 1'b0)
            $display("FAIL ghost_start: got %0d cycles busy=%b required 2 cycles busy=0", log_q.size(), busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        bit sd, bo, lo, po;
        bit reached;
        byte_q_t sr;
        rd_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        log_q.delete();
        @(posedge clk);
        #1;
        start = 1'b1;
        op = 2'b01;
        op_addr = 8'h44;
        op_wdata = 8'h99;
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (log_q.size() >= 4) begin
                reached = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!reached || fb_rw !== 1'b0 || busy !== 1'b1)
            $display("FAIL midop_reach: reached=%0d fb_rw=%b busy=%b required 1 0 1", reached, fb_rw, busy);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, err_timeout, fb_start, fb_rw} !== 6'b000000)
            $display("FAIL midop_reset_ctl: got %b required 000000",
                     {busy, done, err, err_timeout, fb_start, fb_rw});
        else n_pass++;
        n_checks++;
        if ({fb_addr, fb_wdata, rdata, status} !== 32'h0)
            $display("FAIL midop_reset_data: got %h required 00000000", {fb_addr, fb_wdata, rdata, status});
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        exp_status = 8'h00;
        exp_rdata = 8'h00;
        rd_q.delete();
        rd_q.push_back(8'h3C);
        model(2'b00, 8'h5A, 8'h00, 8'h3C, sr);
        run_op(2'b00, 8'h5A, 8'h00, 1'b0, sd, bo, lo, po);
        n_checks++;
        if (!(sd && bo && lo && po) || !log_ok() || rdata !== 8'h3C)
            $display("FAIL post_reset_read: got %b/%0d/%h required 1111/1/3c",
                     {sd, bo, lo, po}, log_ok(), rdata);
        else n_pass++;
    endtask

    task automatic test_random();
        bit sd, bo, lo, po;
        byte_q_t sr;
        logic [1:0] mop;
        logic [7:0] a, wd, rdv, v;
        for (int n = 0; n < 12; n++) begin
            mop = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            wd = 8'($urandom);
            rdv = 8'($urandom);
            sr.delete();
            for (int i = 0; i < POLL_MAX; i++) begin
                v = 8'($urandom);
                v[7] = ($urandom_range(0, 2) == 0);
                sr.push_back(v);
            end
            rd_q.delete();
            if (mop == 2'b00) rd_q.push_back(rdv);
            else if (mop != 2'b11) rd_q = sr;
            model(mop, a, wd, rdv, sr);
            run_op(mop, a, wd, 1'b0, sd, bo, lo, po);
            n_checks++;
            if (!(sd && bo && lo && po) || !log_ok())
                $display("FAIL rand%0d_seq op=%0d: got %b/%0d cycles required 1111/%0d cycles",
                         n, mop, {sd, bo, lo, po}, log_q.size(), exp_q.size());
            else n_pass++;
            n_checks++;
            if ({rdata, status, err, err_timeout} !== {exp_rdata, exp_status, exp_err, exp_tmo})
                $display("FAIL rand%0d_result op=%0d: got %h %h %b%b required %h %h %b%b", n, mop,
                         rdata, status, err, err_timeout, exp_rdata, exp_status, exp_err, exp_tmo);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_program();
        test_erase_error();
        test_timeout();
        test_clear_ignore();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
